// File: rtl/uart_tx_frame.sv
// UART transmit framer: pops words from a FWFT FIFO and serialises start, data (LSB first),
// optional parity and 1/2 stop bits, with level-controlled break generation.
module uart_tx_frame #(
  parameter int DATA_W     = 9,
  parameter int OVERSAMPLE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              brgen,
  input  logic              enable,
  input  logic              empty,
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        nbits,
  input  logic [1:0]        parity,
  input  logic              stop2,
  input  logic              send_break,
  output logic              data_request,
  output logic              busy,
  output logic              out
);

  localparam int                CNT_W    = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]        NB_MIN   = 4'd5;
  localparam logic [3:0]        NB_MAX   = 4'(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_BREAK  = 3'd6
  } state_t;

  function automatic logic [3:0] clamp_nbits(input logic [3:0] n);
    logic [3:0] r;
    if (n < NB_MIN) begin
      r = NB_MIN;
    end else if (n > NB_MAX) begin
      r = NB_MAX;
    end else begin
      r = n;
    end
    return r;
  endfunction

  // Parity over the low n bits: even = XOR, odd = ~XOR, stick = 1.
  function automatic logic frame_parity(input logic [DATA_W-1:0] d, input logic [3:0] n,
                                        input logic [1:0] mode);
    logic x;
    logic r;
    x = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (4'(i) < n) begin
        x = x ^ d[i];
      end else begin
        x = x;
      end
    end
    case (mode)
      2'b01:   r = x;
      2'b10:   r = ~x;
      2'b11:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [3:0]         bi_r;
  logic [DATA_W-1:0]  sh_r;
  logic [3:0]         nb_r;
  logic               par_en_r;
  logic               par_bit_r;
  logic               stop2_r;

  logic               bit_end_s;
  logic               stop_exit_s;
  logic               decide_s;
  logic [3:0]         nb_clamp_s;

  assign bit_end_s   = brgen & (cnt_r == CNT_LAST);
  assign stop_exit_s = bit_end_s & (((state_r == S_STOP1) & ~stop2_r) | (state_r == S_STOP2));
  assign decide_s    = (state_r == S_IDLE) | stop_exit_s;
  assign nb_clamp_s  = clamp_nbits(nbits);

  // Frame sequencer; the idle decision also runs at the end of the last stop bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      cnt_r        <= '0;
      bi_r         <= 4'd0;
      sh_r         <= '0;
      nb_r         <= NB_MIN;
      par_en_r     <= 1'b0;
      par_bit_r    <= 1'b0;
      stop2_r      <= 1'b0;
      out          <= 1'b1;
      busy         <= 1'b0;
      data_request <= 1'b0;
    end else if (decide_s) begin
      cnt_r <= '0;
      bi_r  <= 4'd0;
      if (send_break) begin
        state_r      <= S_BREAK;
        out          <= 1'b0;
        busy         <= 1'b1;
        data_request <= 1'b0;
      end else if (enable & ~empty) begin
        state_r      <= S_START;
        sh_r         <= data;
        nb_r         <= nb_clamp_s;
        par_en_r     <= (parity != 2'b00);
        par_bit_r    <= frame_parity(data, nb_clamp_s, parity);
        stop2_r      <= stop2;
        out          <= 1'b0;
        busy         <= 1'b1;
        data_request <= 1'b1;
      end else begin
        state_r      <= S_IDLE;
        out          <= 1'b1;
        busy         <= 1'b0;
        data_request <= 1'b0;
      end
    end else begin
      data_request <= 1'b0;
      // Break holds the bit counter so the following mark bit is a full period.
      if (state_r == S_BREAK) begin
        cnt_r <= '0;
      end else if (brgen) begin
        cnt_r <= bit_end_s ? '0 : cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
      case (state_r)
        S_START: begin
          if (bit_end_s) begin
            state_r <= S_DATA;
            out     <= sh_r[0];
          end
        end
        S_DATA: begin
          if (bit_end_s) begin
            if (bi_r == nb_r - 4'd1) begin
              if (par_en_r) begin
                state_r <= S_PARITY;
                out     <= par_bit_r;
              end else begin
                state_r <= S_STOP1;
                out     <= 1'b1;
              end
            end else begin
              bi_r <= bi_r + 4'd1;
              sh_r <= sh_r >> 1;
              out  <= sh_r[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end_s) begin
            state_r <= S_STOP1;
            out     <= 1'b1;
          end
        end
        S_STOP1: begin
          if (bit_end_s) begin
            state_r <= S_STOP2;
          end
        end
        S_STOP2: begin
          out <= 1'b1;
        end
        S_BREAK: begin
          if (!send_break) begin
            state_r <= S_STOP1;
            out     <= 1'b1;
          end
        end
        default: begin
          state_r <= S_IDLE;
          out     <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit framer for the serial IP. It pops words from a first-word-fall-through transmit FIFO and serialises them on `out`. Per-frame programmable data length (5..DATA_W bits), parity mode (none/even/odd/stick), 1 or 2 stop bits and break generation. The bit period is derived from an external baud-rate-generator strobe divided by a parametrised oversample factor.

## Interface
Parameters:
- `DATA_W`, 9: maximum data bits per frame and width of `data`; legal range 5..9.
- `OVERSAMPLE`, 16: `brgen` strobes per bit period; legal range 4..32.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `brgen`  in  1  one-cycle strobe from the baud-rate generator.
- `enable`  in  1  allows new frames to start; sampled only in IDLE.
- `empty`  in  1  FIFO empty flag.
- `data`  in  DATA_W  FIFO head word, valid when `empty`=0.
- `nbits`  in  4  data bits per frame; values <5 are treated as 5, values >DATA_W as DATA_W.
- `parity`  in  2  00 none, 01 even, 10 odd, 11 stick (parity bit = 1).
- `stop2`  in  1  1 = two stop bits.
- `send_break`  in  1  level; requests line break.
- `data_request`  out  1  one-cycle FIFO pop strobe.
- `busy`  out  1  high in every state except IDLE.
- `out`  out  1  serial line; idle/mark = 1.

## Operation
- Bit-period counter `cnt`, 0..OVERSAMPLE-1:
  - Advances only on `brgen`.
  - `bit_end` = `brgen` & (`cnt`==OVERSAMPLE-1); `cnt` wraps to 0 on `bit_end`.
  - `cnt` is held at 0 in IDLE, so every bit, including the start bit, lasts exactly OVERSAMPLE strobes.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
- IDLE: `out`=1.
  - Priority 1: if `send_break`=1, go to BREAK.
  - Priority 2: else if `enable` & !`empty`, in that cycle:
    - latch `data` into shift register `sh`;
    - latch `nbits` (clamped), `parity` and `stop2` into frame config;
    - compute parity over the latched low nbits bits: even = XOR, odd = ~XOR, stick = 1;
    - pulse `data_request`;
    - go to START.
- START: `out`=0; on `bit_end` go to DATA with bit index `bi`=0.
- DATA: `out`=`sh[bi]`, LSB first.
  - On `bit_end`: `bi`++.
  - When `bi`==nbits-1, go to PARITY if parity≠00, else STOP1.
- PARITY: `out`=latched parity bit; on `bit_end` go to STOP1.
- STOP1: `out`=1; on `bit_end` go to STOP2 if latched `stop2`=1, else run the IDLE decision in the same cycle.
  - This gives back-to-back frames with no idle gap.
  - `send_break` still has priority.
- STOP2: `out`=1; on `bit_end` behaves exactly as STOP1's exit.
- BREAK: `out`=0 while `send_break`=1.
  - On deassertion, go to STOP1, giving at least one mark bit before the next frame.
  - `cnt` restarts at 0 on entering STOP1.
- Config inputs changed mid-frame do not affect the current frame.
- `enable` deasserted mid-frame: the current frame completes; no new frame starts.
- `send_break` asserted mid-frame: the current frame completes; BREAK follows.

## Timing
- Reset values: state=IDLE, `cnt`=0, `bi`=0, `out`=1, `busy`=0, `data_request`=0.
- Reset mid-frame: `out`=1 from the next cycle. No pop occurs, and the word being sent is lost.
- `out` and `busy` are registered.
- From the cycle `enable` & !`empty` is sampled in IDLE, `out` falls on the next clock edge.
- `data_request` is high exactly one cycle per frame, coincident with the latch.
- The FIFO must present the next word on `data` by the cycle after the pop.
- Frame length in `brgen` strobes = OVERSAMPLE × (1 + nbits + (parity≠0) + 1 + stop2).
- `brgen` and the IDLE start decision in the same cycle: the strobe is not counted, because `cnt` is held in IDLE.

## Test plan
- **8N1 word, OVERSAMPLE=16, `brgen` every cycle.** `data`=0x55, one word.
  - `out` bits 0,1,0,1,0,1,0,1,0,1, each 16 cycles (160 total).
  - One `data_request` pulse; `busy` low after the stop bit.
- **7E2 word.** `data`=0x41.
  - `out` bits 0 | 1,0,0,0,0,0,1 | 0 | 1,1 (11 bits, 176 cycles).
- **5O1 and stick parity.** `data`=0x1F.
  - 5O1: bits 0 | 1,1,1,1,1 | 0 | 1.
  - Same word with parity=11: parity bit 1.
  - `nbits`=3: behaves as 5.
- **Back-to-back frames.** 0xA5 then 0x3C queued, 8N1.
  - The start bit of word 2 begins the cycle after word 1's stop bit ends.
  - Exactly 2 `data_request` pulses, 320 cycles total.
- **Break.** Assert `send_break` during a frame's data bits; hold for 50 bit times.
  - The frame completes unaltered, then `out`=0 for the hold time.
  - Then ≥16 cycles of `out`=1 before the next start bit.
- **Reset mid-frame.** `reset`=0 during bit 3.
  - Next cycle: `out`=1, `busy`=0, no pop.
  - After release, the next queued word is sent normally.
